// File: rtl/pe_array_pkg.sv
// pe_array_pkg: shared state encoding and timing helpers for the PE array sequencer
package pe_array_pkg;
  typedef enum logic [2:0] {IDLE, LOAD, STREAM, DRAIN, DONE} ctrl_state_e;
  localparam int DEFAULT_ARRAY_SIZE = 2;
  localparam int DEFAULT_DRAIN_BEATS = 2 * DEFAULT_ARRAY_SIZE - 2;
  localparam int DEFAULT_RESULT_LATENCY = 2 * DEFAULT_ARRAY_SIZE - 2;
  function automatic int drain_beats(input int n);
    return 2 * n - 2;
  endfunction
  function automatic int result_latency(input int n);
    return 2 * n - 2;
  endfunction
endpackage

// File: rtl/pe_array_seq_if.sv
// pe_array_seq_if: job, weight, activation, array and result signals of the sequencer
interface pe_array_seq_if #(
  parameter int ARRAY_SIZE = 2,
  parameter int COMPUTE_DATA_WIDTH = 4,
  parameter int ACCUMULATOR_DATA_WIDTH = 16,
  parameter int VEC_W = 8
);
  logic start;
  logic [VEC_W-1:0] num_vectors;
  logic busy;
  logic done;
  logic w_valid;
  logic [ARRAY_SIZE*COMPUTE_DATA_WIDTH-1:0] w_data;
  logic w_ready;
  logic a_valid;
  logic [ARRAY_SIZE*COMPUTE_DATA_WIDTH-1:0] a_data;
  logic a_ready;
  logic load_en;
  logic compute;
  logic [ARRAY_SIZE*COMPUTE_DATA_WIDTH-1:0] ins;
  logic [ARRAY_SIZE*ACCUMULATOR_DATA_WIDTH-1:0] results;
  logic r_valid;
  logic [ARRAY_SIZE*ACCUMULATOR_DATA_WIDTH-1:0] r_data;
  modport master (
    output start, num_vectors, w_valid, w_data, a_valid, a_data, results,
    input busy, done, w_ready, a_ready, load_en, compute, ins, r_valid, r_data
  );
  modport slave (
    input start, num_vectors, w_valid, w_data, a_valid, a_data, results,
    output busy, done, w_ready, a_ready, load_en, compute, ins, r_valid, r_data
  );
endinterface

// File: rtl/pe_skew_line.sv
// pe_skew_line: per-lane delay line, lane i delayed by i enabled beats, lane 0 passes straight through
module pe_skew_line #(
  parameter int LANES = 2,
  parameter int W = 4
) (
  input  logic clk,
  input  logic rst,
  input  logic en_i,
  input  logic [LANES*W-1:0] d_i,
  output logic [LANES*W-1:0] q_o
);
  assign q_o[0 +: W] = d_i[0 +: W];
  for (genvar i = 1; i < LANES; i++) begin : g_lane
    logic [W-1:0] sr_q [i];
    // shift lane i by one stage on every enabled beat
    always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
        sr_q <= '{default: '0};
      end else if (en_i) begin
        sr_q[0] <= d_i[i*W +: W];
        for (int k = 1; k < i; k++) sr_q[k] <= sr_q[k-1];
      end
    end
    assign q_o[i*W +: W] = sr_q[i-1];
  end
endmodule

// File: rtl/pe_array_seq.sv
// pe_array_seq: sequences weight load, skewed activation streaming, drain and result de-skew for a systolic PE array
module pe_array_seq
  import pe_array_pkg::*;
#(
  parameter int ARRAY_SIZE = 2,
  parameter int COMPUTE_DATA_WIDTH = 4,
  parameter int ACCUMULATOR_DATA_WIDTH = 16,
  parameter int MAX_VECTORS = 255,
  parameter int VEC_W = $clog2(MAX_VECTORS + 1)
) (
  input logic clk,
  input logic rst,
  pe_array_seq_if.slave bus
);
  localparam int N = ARRAY_SIZE;
  localparam int CDW = COMPUTE_DATA_WIDTH;
  localparam int ADW = ACCUMULATOR_DATA_WIDTH;
  localparam int DRAIN_N = drain_beats(N);
  localparam int LAT = result_latency(N);
  localparam int CNT_W = (VEC_W > $clog2(2 * N)) ? VEC_W : $clog2(2 * N);
  localparam int WARM_W = $clog2(LAT + 2);
  ctrl_state_e state_q, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d, cnt_inc;
  logic [VEC_W-1:0] nv_q, nv_d, out_q, out_d;
  logic [WARM_W-1:0] warm_q, warm_d;
  logic [N*CDW-1:0] hold_q, hold_d, skew_in, skew_out;
  logic [N*ADW-1:0] dsk_in, dsk_out, col_out, r_data_q, r_data_d;
  logic r_valid_q, idle, adv, comp, emit;
  assign idle = state_q == IDLE;
  assign adv = state_q == STREAM && bus.a_valid;
  assign comp = adv || state_q == DRAIN;
  assign emit = comp && warm_q == WARM_W'(LAT) && out_q != nv_q;
  assign cnt_inc = cnt_q + CNT_W'(1);
  assign skew_in = adv ? bus.a_data : state_q == STREAM ? hold_q : '0;
  for (genvar j = 0; j < N; j++) begin : g_rev
    assign dsk_in[j*ADW +: ADW] = bus.results[(N-1-j)*ADW +: ADW];
    assign col_out[(N-1-j)*ADW +: ADW] = dsk_out[j*ADW +: ADW];
  end
  pe_skew_line #(.LANES(N), .W(CDW)) u_skew (
    .clk(clk), .rst(rst), .en_i(comp), .d_i(skew_in), .q_o(skew_out)
  );
  pe_skew_line #(.LANES(N), .W(ADW)) u_deskew (
    .clk(clk), .rst(rst), .en_i(comp), .d_i(dsk_in), .q_o(dsk_out)
  );
  // job FSM: one counter reused for weight rows, accepted vectors and drain beats
  always_comb begin
    state_d = state_q;
    cnt_d = cnt_q;
    nv_d = nv_q;
    case (state_q)
      IDLE: if (bus.start) begin
        state_d = LOAD;
        cnt_d = '0;
        nv_d = bus.num_vectors;
      end
      LOAD: if (bus.w_valid) begin
        cnt_d = cnt_inc == CNT_W'(N) ? '0 : cnt_inc;
        state_d = cnt_inc != CNT_W'(N) ? LOAD : nv_q != '0 ? STREAM : DONE;
      end
      STREAM: if (bus.a_valid) begin
        cnt_d = cnt_inc == CNT_W'(nv_q) ? '0 : cnt_inc;
        state_d = cnt_inc != CNT_W'(nv_q) ? STREAM : DRAIN_N == 0 ? DONE : DRAIN;
      end
      DRAIN: begin
        cnt_d = cnt_inc == CNT_W'(DRAIN_N) ? '0 : cnt_inc;
        state_d = cnt_inc == CNT_W'(DRAIN_N) ? DONE : DRAIN;
      end
      default: state_d = IDLE;
    endcase
  end
  // row-0 hold, pipeline warm-up and output-beat gating so drain zeros never emit
  always_comb begin
    hold_d = adv ? bus.a_data : idle ? '0 : hold_q;
    warm_d = idle ? '0 : (comp && warm_q != WARM_W'(LAT)) ? warm_q + WARM_W'(1) : warm_q;
    out_d = idle ? '0 : emit ? out_q + VEC_W'(1) : out_q;
    r_data_d = emit ? col_out : r_data_q;
  end
  // state and datapath registers
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= IDLE;
      cnt_q <= '0;
      nv_q <= '0;
      out_q <= '0;
      warm_q <= '0;
      hold_q <= '0;
      r_valid_q <= 1'b0;
      r_data_q <= '0;
    end else begin
      state_q <= state_d;
      cnt_q <= cnt_d;
      nv_q <= nv_d;
      out_q <= out_d;
      warm_q <= warm_d;
      hold_q <= hold_d;
      r_valid_q <= emit;
      r_data_q <= r_data_d;
    end
  end
  assign bus.busy = !idle;
  assign bus.done = state_q == DONE;
  assign bus.w_ready = state_q == LOAD;
  assign bus.a_ready = state_q == STREAM;
  assign bus.load_en = state_q == LOAD && bus.w_valid;
  assign bus.compute = comp;
  assign bus.ins = state_q == LOAD ? bus.w_data : skew_out;
  assign bus.r_valid = r_valid_q;
  assign bus.r_data = r_data_q;
endmodule
